pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controls the 25 MHz camera/VGA PLL: drives its active-high reset and consumes its asynchronous locked output.
- Runs on the 50 MHz board reference clock, so it keeps running while the PLL is reset or unlocked.
- Releases the downstream reset (sys_rst_n) only after lock has been held stable for a programmable time.
- Detects loss of lock, re-asserts downstream reset and retries the PLL with a timeout.

Parameters:
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 500000: cycles to wait for sync'd lock before retrying (10 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive sync'd-lock cycles required before releasing sys_rst_n.
- LOSS_FILTER_CYCLES, 4: consecutive sync'd-unlock cycles in RUN that count as a lock loss.
- MAX_RETRIES, 7: retry limit (used only with PLL_RETRY_LIMIT_EN).

Ports:
- clk, in, 1: 50 MHz reference clock; same net as the PLL refclk.
- rst_n, in, 1: synchronous, active-low reset.
- pll_rst, out, 1: active-high reset to the PLL rst input.
- pll_locked, in, 1: PLL locked output, asynchronous to clk.
- sys_rst_n, out, 1: active-low reset for logic in the 25 MHz domain; asserted asynchronously, released only from RUN.
- ready, out, 1: high in RUN.
- retry_cnt, out, 8: number of PLL reset attempts after the first; saturates at 255.
- timeout_err, out, 1: sticky; set on any lock timeout or lock loss; cleared only by rst_n.

Behaviour:
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give lock_s (2-cycle latency). All decisions use lock_s only.
- Reset values (rst_n low at a clk edge): state=PULSE, pll_rst=1, sys_rst_n=0, ready=0, retry_cnt=0, timeout_err=0, all counters=0, sync flops=0.
- Single counter cnt (width = clog2 of the largest cycle parameter). Cleared on every state entry.
- States and transitions:
  - PULSE: pll_rst=1. When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0.
    - lock_s=1: go to STABLE.
    - cnt==LOCK_TIMEOUT_CYCLES-1 with lock_s=0: set timeout_err, increment retry_cnt, go to PULSE.
  - STABLE: pll_rst=0, sys_rst_n=0.
    - lock_s=0: go to WAIT_LOCK; cnt restarts, no retry increment.
    - cnt==STABLE_CYCLES-1 with lock_s=1: go to RUN.
  - RUN: sys_rst_n=1, ready=1. cnt counts consecutive lock_s=0 cycles and is cleared whenever lock_s=1.
    - cnt reaches LOSS_FILTER_CYCLES: set timeout_err, increment retry_cnt, go to PULSE.
- Output timing: all outputs are registered, decoded from the next state.
  - sys_rst_n rises on the same edge that state becomes RUN.
  - sys_rst_n falls on the same edge RUN is left.
- Minimum startup latency with lock already present: RST_PULSE_CYCLES + 1 (first WAIT_LOCK cycle) + STABLE_CYCLES cycles from rst_n release to sys_rst_n=1, plus the 2-cycle synchronizer latency if lock rises during WAIT_LOCK.
- Glitch shorter than LOSS_FILTER_CYCLES in RUN: ignored, no output change.
- rst_n low mid-operation: every state returns to PULSE on the next edge; sys_rst_n drops immediately (registered).
- retry_cnt saturates at 255 and never wraps.

Optional Feature:
- Macro PLL_RETRY_LIMIT_EN.
- Defined:
  - Adds FAULT state, entered instead of PULSE when a retry would make retry_cnt exceed MAX_RETRIES.
  - In FAULT: pll_rst=1, sys_rst_n=0, ready=0. FAULT is exited only by rst_n.
  - Adds output port fault (1 bit, high in FAULT, reset 0).
- Not defined: retries are unlimited; no fault port; MAX_RETRIES is ignored.

Decomposition:
- Shared package pll_seq_pkg holds:
  - state enum typedef (PULSE, WAIT_LOCK, STABLE, RUN, FAULT);
  - a clog2-based width helper constant function;
  - the 25 MHz/50 MHz frequency constants.
- One natural sub-module: sync_2ff, a generic 2-flop bit synchronizer with synchronous active-low reset to 0. It is reused for other asynchronous status inputs.

Test Plan:
- Nominal lock: RST_PULSE=4, STABLE=8, pll_locked high 10 cycles after rst_n release -> pll_rst high exactly 4 cycles; sys_rst_n rises 8 cycles after lock_s=1; ready=1; retry_cnt=0; timeout_err=0.
- Timeout retry: LOCK_TIMEOUT=20, pll_locked tied 0 for 60 cycles -> pll_rst pulses repeat every 4+20 cycles; retry_cnt increments 0->1->2; timeout_err=1; sys_rst_n stays 0.
- Glitch filter: in RUN with LOSS_FILTER=4, drop pll_locked for 3 cycles -> no change; drop it for 6 cycles -> sys_rst_n=0 within 2+4 cycles of the drop, PULSE entered, retry_cnt+1.
- Lock loss in STABLE: drop pll_locked at STABLE cnt=5 -> return to WAIT_LOCK; retry_cnt unchanged; after relock, a full 8-cycle STABLE window is required.
- Mid-run reset: assert rst_n=0 for 1 cycle in RUN -> next edge sys_rst_n=0, pll_rst=1, retry_cnt=0, timeout_err=0.
- PLL_RETRY_LIMIT_EN with MAX_RETRIES=2, pll_locked=0 -> after the third timeout, fault=1 and pll_rst stays 1 indefinitely; fault clears only on rst_n.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL lock sequencer
package pll_seq_pkg;

    localparam int unsigned REF_CLK_HZ = 50_000_000;
    localparam int unsigned PLL_CLK_HZ = 25_000_000;

    typedef enum logic [2:0] {
        PULSE     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Width that holds the largest count value; the loss filter reaches its limit value itself.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 2-flop synchronizer with synchronous active-low reset to 0
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer gating the 25 MHz domain reset
// Optional retry limit with FAULT state and fault port: define PLL_RETRY_LIMIT_EN.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = REF_CLK_HZ / 100,
    parameter int unsigned STABLE_CYCLES       = 1024,
    parameter int unsigned LOSS_FILTER_CYCLES  = 4,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pll_rst,
    input  logic       pll_locked,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] retry_cnt,
    output logic       timeout_err
`ifdef PLL_RETRY_LIMIT_EN
    ,
    output logic       fault
`endif
);

    localparam int unsigned CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                              STABLE_CYCLES, LOSS_FILTER_CYCLES);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PULSE_LAST   = cnt_t'(RST_PULSE_CYCLES - 1);
    localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
    localparam cnt_t STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
    localparam cnt_t LOSS_LAST    = cnt_t'(LOSS_FILTER_CYCLES - 1);

    logic       lock_s;
    pll_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] retry_cnt_q, retry_cnt_d;
    logic       timeout_err_q, timeout_err_d;
    logic       pll_rst_q, sys_rst_n_q, ready_q;
    logic       retry_hit;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (pll_locked),
        .q_o  (lock_s)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + cnt_t'(1);
        retry_cnt_d   = retry_cnt_q;
        timeout_err_d = timeout_err_q;
        retry_hit     = 1'b0;

        case (state_q)
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_hit = 1'b1;
                end
            end
            STABLE: begin
                // Any unlock restarts the wait for lock without counting as a retry.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOSS_LAST) begin
                    retry_hit = 1'b1;
                end
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
        endcase

        if (retry_hit) begin
            timeout_err_d = 1'b1;
            cnt_d         = '0;
`ifdef PLL_RETRY_LIMIT_EN
            if (32'(retry_cnt_q) >= MAX_RETRIES) begin
                state_d = FAULT;
            end else begin
                state_d     = PULSE;
                retry_cnt_d = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
            end
`else
            state_d     = PULSE;
            retry_cnt_d = (retry_cnt_q == 8'hFF) ? 8'hFF : retry_cnt_q + 8'd1;
`endif
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    logic fault_q;
`else
    // MAX_RETRIES only bounds retries when the limit is compiled in.
    if (MAX_RETRIES == 0) begin : g_no_retry_limit
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= PULSE;
            cnt_q         <= '0;
            retry_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            ready_q       <= 1'b0;
`ifdef PLL_RETRY_LIMIT_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            timeout_err_q <= timeout_err_d;
            // Outputs decode the next state so they change on the same edge as the state.
            pll_rst_q     <= (state_d == PULSE) || (state_d == FAULT);
            sys_rst_n_q   <= (state_d == RUN);
            ready_q       <= (state_d == RUN);
`ifdef PLL_RETRY_LIMIT_EN
            fault_q       <= (state_d == FAULT);
`endif
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign retry_cnt   = retry_cnt_q;
    assign timeout_err = timeout_err_q;
`ifdef PLL_RETRY_LIMIT_EN
    assign fault       = fault_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    localparam int P = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int L = 4;
    localparam int M = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] retry_cnt;
    logic       timeout_err;
`ifdef PLL_RETRY_LIMIT_EN
    logic       fault;
`endif

    int errors = 0;
    int checks = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (P),
        .LOCK_TIMEOUT_CYCLES(T),
        .STABLE_CYCLES      (S),
        .LOSS_FILTER_CYCLES (L),
        .MAX_RETRIES        (M)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_rst    (pll_rst),
        .pll_locked (pll_locked),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .retry_cnt  (retry_cnt),
        .timeout_err(timeout_err)
`ifdef PLL_RETRY_LIMIT_EN
        ,
        .fault      (fault)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        repeat (hold) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] exp, obs;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'($urandom);
            tick();
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
            obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset i=%0d got=%b exp=%b", i, obs, exp);
            end
`ifdef PLL_RETRY_LIMIT_EN
            checks++;
            if (fault !== 1'b0) begin
                errors++;
                $display("FAIL reset_fault got=%b exp=0", fault);
            end
`endif
        end
    endtask

    task automatic test_nominal();
        for (int it = 0; it < 4; it++) begin
            int a, e, r;
            logic [11:0] exp, obs;
            a = (it == 0) ? 10 : int'($urandom_range(0, 14));
            do_reset(2);
            e = (a + 3 > P + 1) ? a + 3 : P + 1;
            r = e + S;
            for (int n = 0; n <= r + 3; n++) begin
                exp = {n < P, n >= r, n >= r, 1'b0, 8'd0};
                obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL nominal a=%0d n=%0d got=%b exp=%b", a, n, obs, exp);
                end
                pll_locked = (n >= a);
                tick();
            end
        end
    endtask

    task automatic test_timeout();
        logic [11:0] exp, obs;
        do_reset(2);
        for (int n = 0; n <= 60; n++) begin
            exp = {(n % (P + T)) < P, 1'b0, 1'b0, n >= P + T, 8'(n / (P + T))};
            obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout n=%0d got=%b exp=%b", n, obs, exp);
            end
            pll_locked = 1'b0;
            tick();
        end
    endtask

    task automatic test_stable_loss();
        for (int it = 0; it < 3; it++) begin
            int e, d, h, r;
            logic [11:0] exp, obs;
            do_reset(2);
            e = P + 1;
            d = (it == 0) ? e + 3 : int'($urandom_range(e - 2, e + S - 3));
            h = int'($urandom_range(1, 3));
            r = d + h + 3 + S;
            for (int n = 0; n <= r + 3; n++) begin
                exp = {n < P, n >= r, n >= r, 1'b0, 8'd0};
                obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL stable_loss d=%0d h=%0d n=%0d got=%b exp=%b", d, h, n, obs, exp);
                end
                pll_locked = !(n >= d && n < d + h);
                tick();
            end
        end
    endtask

    task automatic test_glitch();
        int g, sep, x, e, r;
        logic [11:0] exp, obs;
        do_reset(2);
        pll_locked = 1'b1;
        repeat (P + 1 + S) tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        for (int i = 0; i < 6; i++) begin
            g = int'($urandom_range(1, L - 1));
            sep = int'($urandom_range(1, 6));
            for (int j = 0; j < g + sep + ((i == 5) ? 4 : 0); j++) begin
                obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL glitch_short g=%0d j=%0d got=%b exp=%b", g, j, obs, exp);
                end
                pll_locked = (j >= g);
                tick();
            end
        end
        for (int i = 0; i < 2; i++) begin
            g = int'($urandom_range(L, L + 4));
            x = 2 + L;
            e = (x + P + 1 > g + 3) ? x + P + 1 : g + 3;
            r = e + S;
            for (int m = 0; m <= r + 2; m++) begin
                exp = {m >= x && m < x + P, m < x || m >= r, m < x || m >= r,
                       i > 0 || m >= x, 8'(i + ((m >= x) ? 1 : 0))};
                obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL glitch_loss g=%0d m=%0d got=%b exp=%b", g, m, obs, exp);
                end
                pll_locked = (m >= g);
                tick();
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic [11:0] exp, obs;
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 8'd2};
        obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL midrun_pre got=%b exp=%b", obs, exp);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n <= P + 1 + S + 2; n++) begin
            exp = {n < P, n >= P + 1 + S, n >= P + 1 + S, 1'b0, 8'd0};
            obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midrun_reset n=%0d got=%b exp=%b", n, obs, exp);
            end
            pll_locked = 1'b1;
            tick();
        end
    endtask

`ifdef PLL_RETRY_LIMIT_EN
    task automatic test_retry_limit();
        logic [11:0] exp, obs;
        logic        fault_e;
        int          tries;
        do_reset(2);
        for (int n = 0; n <= 110; n++) begin
            fault_e = (n >= 3 * (P + T));
            tries = n / (P + T);
            exp = {fault_e || ((n % (P + T)) < P), 1'b0, 1'b0, n >= P + T,
                   8'((tries > M) ? M : tries)};
            obs = {pll_rst, sys_rst_n, ready, timeout_err, retry_cnt};
            checks++;
            if (obs !== exp || fault !== fault_e) begin
                errors++;
                $display("FAIL retry_limit n=%0d got=%b/%b exp=%b/%b", n, obs, fault, exp, fault_e);
            end
            pll_locked = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (fault !== 1'b0 || pll_rst !== 1'b1 || retry_cnt !== 8'd0) begin
            errors++;
            $display("FAIL fault_clear got=%b/%b/%0d exp=0/1/0", fault, pll_rst, retry_cnt);
        end
    endtask
`else
    task automatic test_saturation();
        int tries;
        do_reset(2);
        for (int n = 0; n <= 257 * (P + T); n++) begin
            tries = n / (P + T);
            checks++;
            if (retry_cnt !== 8'((tries > 255) ? 255 : tries)) begin
                errors++;
                $display("FAIL saturation n=%0d got=%0d exp=%0d", n, retry_cnt, (tries > 255) ? 255 : tries);
            end
            pll_locked = 1'b0;
            tick();
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_nominal();
        test_timeout();
        test_stable_loss();
        test_glitch();
        test_midrun_reset();
`ifdef PLL_RETRY_LIMIT_EN
        test_retry_limit();
`else
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
